// File: rtl/adt_temp_proc_pkg.sv
// rtl/adt_temp_proc_pkg.sv - shared states, default limits and step helper for adt_temp_proc
package adt_temp_proc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_PER,
        ST_REQ,
        ST_WAIT_DATA,
        ST_PROC,
        ST_ERR
    } adt_state_t;

    localparam logic [23:0]        DEF_PERIOD   = 24'd100000;
    localparam logic [15:0]        DEF_TMO_CNT  = 16'd50000;
    localparam logic signed [15:0] DEF_HI_LIM   = 16'sh3E80;
    localparam logic signed [15:0] DEF_LO_LIM   = 16'shEC00;
    localparam logic [15:0]        DEF_MAX_STEP = 16'h0280;
    localparam logic [1:0]         DEF_TMO_MAX  = 2'd3;

    // Magnitude of a - b, computed in 17 bits so full-scale swings cannot wrap.
    function automatic logic [16:0] abs_diff(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] d;
        d = {a[15], a} - {b[15], b};
        return d[16] ? (~d + 17'd1) : d;
    endfunction

endpackage

// File: rtl/adt_temp_proc_avg4.sv
// rtl/adt_temp_proc_avg4.sv - adt_avg4: four-sample window with prefill on first write
module adt_avg4 (
    input  logic        clk_sys,
    input  logic        rst_sys_n,
    input  logic        wr_en,
    input  logic        first,
    input  logic [15:0] din,
    output logic [15:0] avg
);

    // The window is din plus the three previously accepted samples, so avg is
    // already valid in the cycle the new sample is presented.
    logic [15:0]        hist0, hist1, hist2;
    logic [15:0]        s1, s2, s3;
    logic signed [17:0] sum;

    always_comb begin
        s1  = first ? din : hist0;
        s2  = first ? din : hist1;
        s3  = first ? din : hist2;
        sum = {{2{din[15]}}, din} + {{2{s1[15]}}, s1}
            + {{2{s2[15]}}, s2} + {{2{s3[15]}}, s3};
        avg = 16'(sum >>> 2);
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            hist0 <= 16'h0000;
            hist1 <= 16'h0000;
            hist2 <= 16'h0000;
        end else if (wr_en) begin
            hist0 <= din;
            hist1 <= s1;
            hist2 <= s2;
        end
    end

endmodule

// File: rtl/adt_temp_proc.sv
// rtl/adt_temp_proc.sv - ADT7310 sample request, step/range qualification; ADT_AVG_EN adds 4-sample averaging
module adt_temp_proc
    import adt_temp_proc_pkg::*;
#(
    parameter logic [23:0]        PERIOD   = DEF_PERIOD,
    parameter logic [15:0]        TMO_CNT  = DEF_TMO_CNT,
    parameter logic signed [15:0] HI_LIM   = DEF_HI_LIM,
    parameter logic signed [15:0] LO_LIM   = DEF_LO_LIM,
    parameter logic [15:0]        MAX_STEP = DEF_MAX_STEP,
    parameter logic [1:0]         TMO_MAX  = DEF_TMO_MAX
) (
    input  logic        clk_sys,
    input  logic        rst_sys_n,
    input  logic        con_done,
    input  logic        chip_err,
    input  logic        spi_busy,
    input  logic        rd_dval,
    input  logic [15:0] rd_dvalue,
    output logic        rd_en,
    output logic [15:0] temp_val,
    output logic        temp_dval,
    output logic        temp_ok,
    output logic        over_alm,
    output logic        under_alm,
    output logic [7:0]  step_err_cnt,
    output logic        tmo_err
);

    adt_state_t  state;
    logic [23:0] per_cnt;
    logic [15:0] tmo_cnt;
    logic [1:0]  tmo_run;
    logic [15:0] sample;
    logic [15:0] last_acc;
    logic        have_acc;
    logic        step_bad;
    logic [15:0] avg_val;

    assign step_bad = have_acc && (abs_diff(sample, last_acc) > {1'b0, MAX_STEP});

`ifdef ADT_AVG_EN
    adt_avg4 u_avg4 (
        .clk_sys   (clk_sys),
        .rst_sys_n (rst_sys_n),
        .wr_en     ((state == ST_PROC) && !step_bad && !chip_err),
        .first     (!have_acc),
        .din       (sample),
        .avg       (avg_val)
    );
`else
    assign avg_val = sample;
`endif

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state        <= ST_IDLE;
            per_cnt      <= 24'd0;
            tmo_cnt      <= 16'd0;
            tmo_run      <= 2'd0;
            sample       <= 16'h0000;
            last_acc     <= 16'h0000;
            have_acc     <= 1'b0;
            rd_en        <= 1'b0;
            temp_val     <= 16'h0000;
            temp_dval    <= 1'b0;
            temp_ok      <= 1'b0;
            over_alm     <= 1'b0;
            under_alm    <= 1'b0;
            step_err_cnt <= 8'd0;
            tmo_err      <= 1'b0;
        end else begin
            rd_en     <= 1'b0;
            temp_dval <= 1'b0;
            // Free-running until PERIOD-1, then parked there until a request goes out.
            if (per_cnt != PERIOD - 24'd1)
                per_cnt <= per_cnt + 24'd1;

            if (chip_err) begin
                state   <= ST_ERR;
                temp_ok <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        per_cnt <= 24'd0;
                        if (con_done)
                            state <= ST_WAIT_PER;
                    end
                    ST_WAIT_PER: begin
                        if (!con_done) begin
                            state <= ST_IDLE;
                        end else if (per_cnt == PERIOD - 24'd1 && !spi_busy) begin
                            state <= ST_REQ;
                            rd_en <= 1'b1;
                        end
                    end
                    ST_REQ: begin
                        per_cnt <= 24'd0;
                        tmo_cnt <= 16'd0;
                        state   <= con_done ? ST_WAIT_DATA : ST_IDLE;
                    end
                    ST_WAIT_DATA: begin
                        if (!con_done) begin
                            state <= ST_IDLE;
                        end else if (rd_dval) begin
                            sample  <= rd_dvalue;
                            tmo_run <= 2'd0;
                            state   <= ST_PROC;
                        end else if (tmo_cnt == TMO_CNT - 16'd1) begin
                            tmo_run <= tmo_run + 2'd1;
                            if (tmo_run + 2'd1 == TMO_MAX) begin
                                tmo_err <= 1'b1;
                                temp_ok <= 1'b0;
                                state   <= ST_ERR;
                            end else begin
                                state   <= ST_WAIT_PER;
                            end
                        end else begin
                            tmo_cnt <= tmo_cnt + 16'd1;
                        end
                    end
                    ST_PROC: begin
                        state <= ST_WAIT_PER;
                        if (step_bad) begin
                            if (step_err_cnt != 8'hFF)
                                step_err_cnt <= step_err_cnt + 8'd1;
                        end else begin
                            last_acc  <= sample;
                            have_acc  <= 1'b1;
                            temp_val  <= avg_val;
                            temp_dval <= 1'b1;
                            temp_ok   <= 1'b1;
                            over_alm  <= $signed(sample) > HI_LIM;
                            under_alm <= $signed(sample) < LO_LIM;
                        end
                    end
                    default: begin
                        state <= ST_ERR;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adt_temp_proc.sv
// tb/tb_adt_temp_proc.sv - directed self-checking bench for adt_temp_proc
module tb_adt_temp_proc;

    logic        clk_sys   = 1'b0;
    logic        rst_sys_n = 1'b0;
    logic        con_done  = 1'b0;
    logic        chip_err  = 1'b0;
    logic        spi_busy  = 1'b0;
    logic        rd_dval   = 1'b0;
    logic [15:0] rd_dvalue = 16'h0000;
    logic        rd_en;
    logic [15:0] temp_val;
    logic        temp_dval;
    logic        temp_ok;
    logic        over_alm;
    logic        under_alm;
    logic [7:0]  step_err_cnt;
    logic        tmo_err;

    localparam int PER = 60;
    localparam int TMO = 40;

`ifdef ADT_AVG_EN
    localparam logic [15:0] EXP_S1 = 16'h0CA0;
    localparam logic [15:0] EXP_S2 = 16'h0CE0;
    localparam logic [15:0] EXP_S3 = 16'h0D40;
`else
    localparam logic [15:0] EXP_S1 = 16'h0D00;
    localparam logic [15:0] EXP_S2 = 16'h0D80;
    localparam logic [15:0] EXP_S3 = 16'h0E00;
`endif

    adt_temp_proc #(
        .PERIOD  (24'(PER)),
        .TMO_CNT (16'(TMO))
    ) dut (
        .clk_sys      (clk_sys),
        .rst_sys_n    (rst_sys_n),
        .con_done     (con_done),
        .chip_err     (chip_err),
        .spi_busy     (spi_busy),
        .rd_dval      (rd_dval),
        .rd_dvalue    (rd_dvalue),
        .rd_en        (rd_en),
        .temp_val     (temp_val),
        .temp_dval    (temp_dval),
        .temp_ok      (temp_ok),
        .over_alm     (over_alm),
        .under_alm    (under_alm),
        .step_err_cnt (step_err_cnt),
        .tmo_err      (tmo_err)
    );

    always #5 clk_sys = ~clk_sys;

    int          ncmp = 0;
    int          nerr = 0;
    int          m1, m2, m3;
    bit          mfirst;
    logic [15:0] last_e;
    time         t_req;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input int limit, output bit got);
        got = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk_sys);
            if (rd_en) begin
                got   = 1'b1;
                t_req = $time;
                break;
            end
        end
    endtask

    // Answer the next request 20 cycles after rd_en; returns at the sample point
    // two cycles after rd_dval was taken.
    task automatic deliver(input logic [15:0] v, input string tag);
        bit got;
        wait_req(200, got);
        chk({tag, "_req"}, 32'(got), 32'd1);
        repeat (20) @(posedge clk_sys);
        #1 rd_dval = 1'b1; rd_dvalue = v;
        @(posedge clk_sys);
        #1 rd_dval = 1'b0; rd_dvalue = 16'h0000;
        @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    task automatic expect_acc(input logic [15:0] v, input string tag);
        int s;
        int sum;
        logic [15:0] e;
        deliver(v, tag);
        s = $signed(v);
        if (mfirst) begin
            m1 = s; m2 = s; m3 = s;
            mfirst = 1'b0;
        end
        sum = s + m1 + m2 + m3;
        m3 = m2; m2 = m1; m1 = s;
`ifdef ADT_AVG_EN
        e = 16'(sum >>> 2);
`else
        e = v;
`endif
        last_e = e;
        chk({tag, "_dval"}, 32'(temp_dval), 32'd1);
        chk({tag, "_val"}, 32'(temp_val), 32'(e));
        chk({tag, "_over"}, 32'(over_alm), 32'(s > 16000));
        chk({tag, "_under"}, 32'(under_alm), 32'(s < -5120));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
        chk({tag, "_temp_val"}, 32'(temp_val), 32'd0);
        chk({tag, "_temp_dval"}, 32'(temp_dval), 32'd0);
        chk({tag, "_temp_ok"}, 32'(temp_ok), 32'd0);
        chk({tag, "_over"}, 32'(over_alm), 32'd0);
        chk({tag, "_under"}, 32'(under_alm), 32'd0);
        chk({tag, "_step_cnt"}, 32'(step_err_cnt), 32'd0);
        chk({tag, "_tmo_err"}, 32'(tmo_err), 32'd0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit  got;
        int  v;
        time t0;

        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        check_reset_outputs("reset");
        @(posedge clk_sys);
        #1 rst_sys_n = 1'b1;

        wait_req(150, got);
        chk("idle_no_req", 32'(got), 32'd0);

        #1 con_done = 1'b1;
        mfirst = 1'b1;
        expect_acc(16'h0C80, "s0");
        t0 = t_req;
        chk("s0_ok", 32'(temp_ok), 32'd1);
        chk("s0_const", 32'(temp_val), 32'h0C80);
        @(negedge clk_sys);
        chk("dval_pulse", 32'(temp_dval), 32'd0);

        expect_acc(16'h0D00, "s1");
        chk("req_spacing", 32'(int'((t_req - t0) / 10)), 32'(PER + 1));
        chk("s1_const", 32'(temp_val), 32'(EXP_S1));
        expect_acc(16'h0D80, "s2");
        chk("s2_const", 32'(temp_val), 32'(EXP_S2));
        expect_acc(16'h0E00, "s3");
        chk("s3_const", 32'(temp_val), 32'(EXP_S3));

        deliver(16'h1100, "rej");
        chk("rej_dval", 32'(temp_dval), 32'd0);
        chk("rej_cnt", 32'(step_err_cnt), 32'd1);
        chk("rej_val", 32'(temp_val), 32'(last_e));

        expect_acc(16'h1080, "step_edge");
        chk("step_edge_cnt", 32'(step_err_cnt), 32'd1);

        v = 16'h1080;
        while (v + 640 <= 16000) begin
            v += 640;
            expect_acc(16'(v), "up");
        end
        expect_acc(16'h3E80, "hi_edge");
        expect_acc(16'h3E81, "hi_over");
        chk("over_set", 32'(over_alm), 32'd1);

        v = 16001;
        while (v - 640 >= -5120) begin
            v -= 640;
            expect_acc(16'(v), "down");
        end
        expect_acc(16'hEC00, "lo_edge");
        expect_acc(16'hEBFF, "lo_under");
        chk("under_set", 32'(under_alm), 32'd1);

        for (int k = 0; k < 3; k++) begin
            wait_req(200, got);
            chk("tmo_req", 32'(got), 32'd1);
            repeat (TMO + 5) @(negedge clk_sys);
            chk("tmo_err_flag", 32'(tmo_err), 32'(k == 2));
        end
        chk("tmo_ok", 32'(temp_ok), 32'd0);
        wait_req(200, got);
        chk("tmo_no_req", 32'(got), 32'd0);

        rst_sys_n = 1'b0;
        #1 check_reset_outputs("rst_err");
        @(posedge clk_sys);
        #1 rst_sys_n = 1'b1;
        mfirst = 1'b1;
        expect_acc(16'h0C80, "after_rst");
        chk("after_rst_ok", 32'(temp_ok), 32'd1);
        wait_req(200, got);
        chk("mid_req", 32'(got), 32'd1);
        repeat (5) @(negedge clk_sys);
        rst_sys_n = 1'b0;
        #1 check_reset_outputs("rst_mid");
        @(posedge clk_sys);
        #1 rst_sys_n = 1'b1;

        mfirst = 1'b1;
        expect_acc(16'h0C80, "pre_chip");
        wait_req(200, got);
        chk("chip_req", 32'(got), 32'd1);
        repeat (5) @(posedge clk_sys);
        #1 chip_err = 1'b1;
        repeat (2) @(negedge clk_sys);
        chk("chip_ok", 32'(temp_ok), 32'd0);
        #1 chip_err = 1'b0;
        wait_req(200, got);
        chk("chip_no_req", 32'(got), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
